cmt_trap_ctrl: RTL
==================

CMT_TRAP_CTRL -- requirements
Module: cmt_trap_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of level interrupt lines (1..16).
REQ-002 SHALL have parameter PC_W, default 32, PC/address width.
REQ-003 SHALL have parameter XLEN, default 32, cause/mtvec width.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port cmt_i_valid, input, 1, instruction presented for commit.
REQ-008 SHALL have port cmt_i_ready, input, 1, EXU ready; accept = valid & ready & ~cmt_stall.
REQ-009 SHALL have ports cmt_i_pc, input, PC_W, instruction PC; cmt_i_badaddr, input, PC_W, faulting address.
REQ-010 SHALL have ports cmt_i_excp_vld, input, 1, synchronous exception; cmt_i_excp_code, input, 4, exception code.
REQ-011 SHALL have ports cmt_i_mret, cmt_i_wfi, cmt_i_bjp_flush, input, 1 each; cmt_i_bjp_pc, input, PC_W.
REQ-012 SHALL have ports irq_i, irq_en_i, input, NUM_IRQ, pending lines and per-line enables; status_mie_r, input, 1.
REQ-013 SHALL have ports csr_mtvec_r, input, XLEN; csr_mepc_r, input, PC_W.
REQ-014 SHALL have outputs flush_req 1, flush_pc PC_W, cmt_stall 1, core_wfi 1, cmt_instret_ena 1, cmt_mret_ena 1.
REQ-015 SHALL have outputs cmt_epc PC_W, cmt_cause XLEN, cmt_badaddr PC_W, and cmt_epc_ena, cmt_cause_ena, cmt_badaddr_ena, 1 each.

Function
REQ-016 SHALL implement FSM states IDLE, TRAP, WFI.
REQ-017 SHALL compute irq_take = status_mie_r & |(irq_i & irq_en_i); winner = lowest set index.
REQ-018 SHALL, in IDLE on accept, apply priority: exception > irq_take > mret > wfi > bjp_flush > plain retire.
REQ-019 SHALL, on exception: latch epc=cmt_i_pc, cause={0,code}, badaddr; go TRAP; no instret.
REQ-020 SHALL, on irq: latch epc=cmt_i_pc, cause={1'b1, 16+index}; badaddr_ena stays 0; go TRAP; no instret.
REQ-021 SHALL hold TRAP exactly one cycle: assert all latched *_ena, flush_req=1, flush_pc per REQ-033; cmt_stall=1; then go IDLE.
REQ-022 SHALL, on mret, assert cmt_mret_ena, cmt_instret_ena, flush_req and flush_pc=csr_mepc_r combinationally in the accept cycle.
REQ-023 SHALL, on bjp_flush, assert flush_req with flush_pc=cmt_i_bjp_pc in the same cycle, plus cmt_instret_ena.
REQ-024 SHALL, on wfi, retire the instruction, latch epc=cmt_i_pc+4, and go WFI.
REQ-025 SHALL, in WFI, hold core_wfi=1 and cmt_stall=1.
REQ-026 SHALL, in WFI when |(irq_i & irq_en_i): go TRAP with irq cause if status_mie_r, else IDLE; wake ignores status_mie_r.
REQ-027 SHALL keep flush_req, all *_ena and cmt_instret_ena at 0 whenever no accept occurs in IDLE; cmt_stall=0 in IDLE.
REQ-028 SHALL sample irq_i only at accept or in WFI; a pulse dropped before sampling is lost.

Reset
REQ-029 SHALL drive FSM to IDLE and clear every output and latched register to 0 on rst, including mid-TRAP/WFI.
REQ-030 SHALL accept its first commit in the first cycle after rst deasserts.

Configuration
REQ-031 SHALL honour macro CMT_VECTORED_IRQ_EN.
REQ-032 SHALL, with CMT_VECTORED_IRQ_EN defined and csr_mtvec_r[1:0]==01, set irq flush_pc = {mtvec[PC_W-1:2],2'b00} + 4*cause[4:0]; exceptions use base.
REQ-033 SHALL, without the macro, always use flush_pc = {mtvec[PC_W-1:2],2'b00} (mode bits ignored).

Structure
REQ-034 SHALL place state encoding, IRQ cause offset (16) and interrupt cause bit position in shared package cmt_pkg.
REQ-035 SHALL contain one sub-module cmt_irq_prio: NUM_IRQ-wide fixed-priority encoder returning valid + index.

Verification
REQ-036 SHALL cover: excp_vld, code=2, pc=0x100, mtvec=0x800 -> next cycle flush_pc=0x800, epc=0x100, cause=2, instret=0.
REQ-037 SHALL cover: irq_i=4'b0110, en=4'b1111, mie=1 at pc=0x200 -> cause=0x80000011, epc=0x200; vectored build, mode=01 -> flush_pc=0x844.
REQ-038 SHALL cover: wfi at 0x300, mie=0 -> core_wfi until irq_i[0]; then IDLE, no trap; with mie=1 -> TRAP, epc=0x304.
REQ-039 SHALL cover: excp_vld and bjp_flush together -> exception trap only; bjp_pc not used.
REQ-040 SHALL cover: rst asserted in TRAP -> all outputs 0 same cycle, IDLE after release.

Source files
------------

// File: rtl/cmt_pkg.sv
// cmt_pkg: shared definitions for the commit/trap controller.
//   - cmt_state_e   : controller FSM state encoding
//   - IRQ_CAUSE_OFS : interrupt cause code = IRQ_CAUSE_OFS + line index
//   - IRQ_IDX_W     : width of the interrupt index (up to 16 lines)
//   - cause_int_bit : bit position of the interrupt flag within an xlen-wide cause
package cmt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_WFI  = 2'd2
  } cmt_state_e;

  localparam int unsigned IRQ_CAUSE_OFS = 16;
  localparam int          IRQ_IDX_W     = 4;

  // The interrupt flag lives in the most significant bit of the cause value.
  function automatic int unsigned cause_int_bit(input int unsigned xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/cmt_irq_prio.sv
// cmt_irq_prio: fixed-priority encoder over the pending-and-enabled interrupt lines.
// Line 0 has the highest priority.
// Ports:
//   req   [NUM_IRQ-1:0]  in   pending & enabled lines
//   valid                out  any line requesting
//   idx   [IRQ_IDX_W-1:0] out index of the lowest set line (0 when none)
module cmt_irq_prio
  import cmt_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]   req,
  output logic                 valid,
  output logic [IRQ_IDX_W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downward so the last hit written is the lowest index.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IRQ_IDX_W'(i);
    end
  end

endmodule

// File: rtl/cmt_trap_ctrl.sv
// cmt_trap_ctrl: commit-stage trap controller.
// Accepts one instruction per cycle from the EXU and decides, in priority order,
// between a synchronous exception, an interrupt, mret, wfi, a branch flush or a
// plain retire. Traps spend one cycle in TRAP where the latched epc/cause/badaddr
// are published and the pipeline is flushed to the trap vector. wfi parks the
// controller in WFI until an enabled line is pending.
//
// Optional feature: macro CMT_VECTORED_IRQ_EN enables vectored interrupt dispatch
// (mtvec mode 01 -> base + 4*cause[4:0] for interrupts). Without it the trap target
// is always the mtvec base and the mode bits are ignored.
//
// Ports:
//   clk, rst (async, active-high)
//   cmt_i_valid/ready, cmt_i_pc, cmt_i_badaddr, cmt_i_excp_vld/code,
//   cmt_i_mret, cmt_i_wfi, cmt_i_bjp_flush, cmt_i_bjp_pc    commit request
//   irq_i, irq_en_i, status_mie_r, csr_mtvec_r, csr_mepc_r   interrupt / CSR state
//   flush_req, flush_pc, cmt_stall, core_wfi                 pipeline control
//   cmt_instret_ena, cmt_mret_ena                            retire strobes
//   cmt_epc/_ena, cmt_cause/_ena, cmt_badaddr/_ena           CSR write-back
module cmt_trap_ctrl
  import cmt_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int PC_W    = 32,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmt_i_valid,
  input  logic               cmt_i_ready,
  input  logic [PC_W-1:0]    cmt_i_pc,
  input  logic [PC_W-1:0]    cmt_i_badaddr,
  input  logic               cmt_i_excp_vld,
  input  logic [3:0]         cmt_i_excp_code,
  input  logic               cmt_i_mret,
  input  logic               cmt_i_wfi,
  input  logic               cmt_i_bjp_flush,
  input  logic [PC_W-1:0]    cmt_i_bjp_pc,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               status_mie_r,
  input  logic [XLEN-1:0]    csr_mtvec_r,
  input  logic [PC_W-1:0]    csr_mepc_r,
  output logic               flush_req,
  output logic [PC_W-1:0]    flush_pc,
  output logic               cmt_stall,
  output logic               core_wfi,
  output logic               cmt_instret_ena,
  output logic               cmt_mret_ena,
  output logic [PC_W-1:0]    cmt_epc,
  output logic [XLEN-1:0]    cmt_cause,
  output logic [PC_W-1:0]    cmt_badaddr,
  output logic               cmt_epc_ena,
  output logic               cmt_cause_ena,
  output logic               cmt_badaddr_ena
);

  localparam int INT_BIT = int'(cause_int_bit(XLEN));

  cmt_state_e state_q, state_d;

  logic [PC_W-1:0]      epc_q;
  logic [XLEN-1:0]      cause_q;
  logic [PC_W-1:0]      badaddr_q;
  logic                 bad_vld_q;

  logic                 irq_vld;
  logic [IRQ_IDX_W-1:0] irq_idx;
  logic                 irq_take;
  logic                 accept;
  logic [XLEN-1:0]      irq_cause;
  logic [XLEN-1:0]      excp_cause;
  logic [PC_W-1:0]      mtvec_base;
  logic [PC_W-1:0]      trap_pc;

  logic                 ld_epc_pc;
  logic                 ld_epc_wfi;
  logic                 ld_excp;
  logic                 ld_irq;

  cmt_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req   (irq_i & irq_en_i),
    .valid (irq_vld),
    .idx   (irq_idx)
  );

  assign irq_take = status_mie_r & irq_vld;

  // Gating with rst keeps every strobe at zero while reset is held.
  assign accept = cmt_i_valid & cmt_i_ready & (state_q == ST_IDLE) & ~rst;

  assign excp_cause = {{(XLEN-4){1'b0}}, cmt_i_excp_code};
  assign mtvec_base = PC_W'(csr_mtvec_r) & ~PC_W'(3);

  always_comb begin
    irq_cause          = '0;
    irq_cause[INT_BIT] = 1'b1;
    irq_cause[4:0]     = 5'(IRQ_CAUSE_OFS) + {1'b0, irq_idx};
  end

`ifdef CMT_VECTORED_IRQ_EN
  logic mode_unused;
  assign mode_unused = 1'b0;

  always_comb begin
    trap_pc = mtvec_base;
    if (cause_q[INT_BIT] && (csr_mtvec_r[1:0] == 2'b01))
      trap_pc = mtvec_base + PC_W'({cause_q[4:0], 2'b00});
  end
`else
  // Mode bits only matter for vectored dispatch.
  logic mode_unused;
  assign mode_unused = ^csr_mtvec_r[1:0];
  assign trap_pc     = mtvec_base;
`endif

  always_comb begin
    state_d         = state_q;
    flush_req       = 1'b0;
    flush_pc        = '0;
    cmt_stall       = 1'b0;
    core_wfi        = 1'b0;
    cmt_instret_ena = 1'b0;
    cmt_mret_ena    = 1'b0;
    cmt_epc_ena     = 1'b0;
    cmt_cause_ena   = 1'b0;
    cmt_badaddr_ena = 1'b0;
    ld_epc_pc       = 1'b0;
    ld_epc_wfi      = 1'b0;
    ld_excp         = 1'b0;
    ld_irq          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmt_i_excp_vld) begin
            ld_epc_pc = 1'b1;
            ld_excp   = 1'b1;
            state_d   = ST_TRAP;
          end else if (irq_take) begin
            ld_epc_pc = 1'b1;
            ld_irq    = 1'b1;
            state_d   = ST_TRAP;
          end else if (cmt_i_mret) begin
            cmt_mret_ena    = 1'b1;
            cmt_instret_ena = 1'b1;
            flush_req       = 1'b1;
            flush_pc        = csr_mepc_r;
          end else if (cmt_i_wfi) begin
            cmt_instret_ena = 1'b1;
            ld_epc_wfi      = 1'b1;
            state_d         = ST_WFI;
          end else if (cmt_i_bjp_flush) begin
            cmt_instret_ena = 1'b1;
            flush_req       = 1'b1;
            flush_pc        = cmt_i_bjp_pc;
          end else begin
            cmt_instret_ena = 1'b1;
          end
        end
      end

      ST_TRAP: begin
        cmt_stall       = 1'b1;
        flush_req       = 1'b1;
        flush_pc        = trap_pc;
        cmt_epc_ena     = 1'b1;
        cmt_cause_ena   = 1'b1;
        cmt_badaddr_ena = bad_vld_q;
        state_d         = ST_IDLE;
      end

      ST_WFI: begin
        cmt_stall = 1'b1;
        core_wfi  = 1'b1;
        // Any enabled line wakes the core; it only traps when mie is set.
        // epc already holds the address after the wfi.
        if (irq_vld) begin
          if (status_mie_r) begin
            ld_irq  = 1'b1;
            state_d = ST_TRAP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
      badaddr_q <= '0;
      bad_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ld_epc_pc)  epc_q <= cmt_i_pc;
      if (ld_epc_wfi) epc_q <= cmt_i_pc + PC_W'(4);
      if (ld_excp) begin
        cause_q   <= excp_cause;
        badaddr_q <= cmt_i_badaddr;
        bad_vld_q <= 1'b1;
      end
      if (ld_irq) begin
        cause_q   <= irq_cause;
        bad_vld_q <= 1'b0;
      end
    end
  end

  assign cmt_epc     = epc_q;
  assign cmt_cause   = cause_q;
  assign cmt_badaddr = badaddr_q;

endmodule
